lb_region_mux: RTL and testbench

//  Parametrised local-bus region splitter and read-return mux for the lb_clk domain of the Marble base.
//  - Decodes one address field into N_CH application regions.
//  - Issues per-region write and read-enable strobes.
//  - Delays the region select to line up with a fixed read latency, then registers the selected read data.
//  - Counts and captures accesses to unmapped addresses.
//  - Replaces the hand-written 3-way (app/mbox/slave) select with a generic N-channel block with fault reporting.

---
 rtl/lb_region_pkg.sv | 43 ++++
 rtl/lb_region_pipe.sv | 41 ++++
 rtl/lb_region_mux.sv | 115 +++++++++++
 tb/tb_lb_region_mux.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lb_region_pkg.sv
// Shared constants and the region decode function for the local-bus region splitter.
package lb_region_pkg;

   localparam int FAULT_W = 16;
   localparam int MAX_CH  = 16;
   localparam int MAX_SW  = 32;
   localparam int IDX_W   = 4;

   typedef struct packed {
      logic [MAX_CH-1:0] onehot;
      logic              unmapped;
      logic [IDX_W-1:0]  idx;
   } grant_t;

   function automatic int region_sw(input int aw, input int sel_lsb);
      return aw - sel_lsb;
   endfunction

   // Lowest matching index wins, so duplicate bases still give a one-hot grant.
   function automatic grant_t region_grant(input logic [MAX_SW-1:0]        field,
                                           input logic [MAX_CH*MAX_SW-1:0] bases,
                                           input int                       n_ch,
                                           input int                       sw);
      grant_t                     g;
      logic [MAX_SW-1:0]          mask;
      logic [MAX_SW-1:0]          base_i;
      logic [MAX_CH*MAX_SW-1:0]   shifted;
      g          = '0;
      g.unmapped = 1'b1;
      mask       = (sw >= MAX_SW) ? '1 : ((MAX_SW'(1) << sw) - MAX_SW'(1));
      for (int i = 0; i < MAX_CH; i++) begin
         shifted = bases >> (i * sw);
         base_i  = shifted[MAX_SW-1:0] & mask;
         if ((i < n_ch) && g.unmapped && ((field & mask) == base_i)) begin
            g.onehot[i] = 1'b1;
            g.unmapped  = 1'b0;
            g.idx       = IDX_W'(i);
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/lb_region_pipe.sv
// Valid-plus-payload shift register; carries the read select until its data is due.
module lb_region_pipe #(
   parameter int DEPTH = 2,
   parameter int W     = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic [DEPTH-1:0]        valid_d, valid_q;
   logic [DEPTH-1:0][W-1:0] data_d,  data_q;

   always_comb begin
      valid_d    = valid_q;
      data_d     = data_q;
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
      for (int k = 1; k < DEPTH; k++) begin
         valid_d[k] = valid_q[k-1];
         data_d[k]  = data_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/lb_region_mux.sv
// Local-bus region splitter: decodes the address field into N_CH regions, issues write and
// read strobes, muxes the delayed read data back and records accesses to unmapped addresses.
module lb_region_mux
   import lb_region_pkg::*;
#(
   parameter int                                N_CH          = 4,
   parameter int                                AW            = 24,
   parameter int                                DW            = 32,
   parameter int                                SEL_LSB       = 20,
   parameter logic [N_CH*(AW-SEL_LSB)-1:0]      BASES         = {4'd3, 4'd2, 4'd1, 4'd0},
   parameter int                                READ_LAT      = 3,
   parameter logic [DW-1:0]                     UNMAPPED_DATA = 32'hdeadf00d
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [AW-1:0]        lb_addr,
   input  logic                 lb_strobe,
   input  logic                 lb_rd,
   output logic [N_CH-1:0]      ch_write,
   output logic [N_CH-1:0]      ch_ren,
   input  logic [N_CH*DW-1:0]   ch_rdata,
   output logic [DW-1:0]        lb_data_in,
   output logic                 lb_rd_valid,
   output logic [FAULT_W-1:0]   fault_count,
   output logic [AW-1:0]        fault_addr
);

   // Bus semantics: lb_strobe qualifies lb_addr/lb_rd for exactly one cycle and there is no
   // back-pressure; lb_rd_valid is a one-cycle pulse READ_LAT cycles after each read strobe.

   localparam int                     SW       = region_sw(AW, SEL_LSB);
   localparam int                     EXT_W    = MAX_CH * MAX_SW;
   localparam logic [EXT_W-1:0]       BASES_X  = EXT_W'(BASES);
   localparam logic [MAX_CH-1:0]      CH_MASK  = MAX_CH'((32'd1 << N_CH) - 32'd1);
   localparam int                     PW       = IDX_W + 1;

   grant_t                grant;
   logic                  unmapped;
   logic [N_CH-1:0]       hit_mask;
   logic                  rd_strobe;
   logic                  wr_strobe;
   logic [N_CH-1:0]       ch_ren_d,      ch_ren_q;
   logic [DW-1:0]         lb_data_d,     lb_data_q;
   logic                  lb_rd_valid_d, lb_rd_valid_q;
   logic [FAULT_W-1:0]    fault_count_d, fault_count_q;
   logic [AW-1:0]         fault_addr_d,  fault_addr_q;
   logic                  sel_valid;
   logic [PW-1:0]         sel_payload;
   logic [DW-1:0]         rd_sel;

   always_comb begin
      grant     = region_grant(MAX_SW'(lb_addr[AW-1:SEL_LSB]), BASES_X, N_CH, SW);
      // A grant outside the configured regions cannot occur, but would be reported as a fault.
      unmapped  = grant.unmapped | (|(grant.onehot & ~CH_MASK));
      hit_mask  = grant.onehot[N_CH-1:0];
      rd_strobe = lb_strobe & lb_rd;
      wr_strobe = lb_strobe & ~lb_rd;
      ch_write  = {N_CH{wr_strobe}} & hit_mask;
      ch_ren_d  = {N_CH{rd_strobe}} & hit_mask;
   end

   lb_region_pipe #(
      .DEPTH (READ_LAT - 1),
      .W     (PW)
   ) u_sel_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_strobe),
      .in_data   ({unmapped, grant.idx}),
      .out_valid (sel_valid),
      .out_data  (sel_payload)
   );

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel_payload[IDX_W-1:0] == IDX_W'(i)) rd_sel = ch_rdata[i*DW +: DW];
      end
      lb_rd_valid_d = sel_valid;
      lb_data_d     = lb_data_q;
      if (sel_valid) lb_data_d = sel_payload[IDX_W] ? UNMAPPED_DATA : rd_sel;
   end

   always_comb begin
      fault_count_d = fault_count_q;
      fault_addr_d  = fault_addr_q;
      if (lb_strobe && unmapped) begin
         fault_addr_d = lb_addr;
         if (fault_count_q != '1) fault_count_d = fault_count_q + FAULT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_ren_q      <= '0;
         lb_data_q     <= '0;
         lb_rd_valid_q <= 1'b0;
         fault_count_q <= '0;
         fault_addr_q  <= '0;
      end else begin
         ch_ren_q      <= ch_ren_d;
         lb_data_q     <= lb_data_d;
         lb_rd_valid_q <= lb_rd_valid_d;
         fault_count_q <= fault_count_d;
         fault_addr_q  <= fault_addr_d;
      end
   end

   assign ch_ren      = ch_ren_q;
   assign lb_data_in  = lb_data_q;
   assign lb_rd_valid = lb_rd_valid_q;
   assign fault_count = fault_count_q;
   assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_lb_region_mux.sv
// Directed bench for lb_region_mux: default decode instance plus one with duplicate bases.
module tb_lb_region_mux;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [23:0]   lb_addr,  lb_addr2;
   logic          lb_strobe, lb_strobe2;
   logic          lb_rd,    lb_rd2;
   logic [3:0]    ch_write, ch_write2;
   logic [3:0]    ch_ren,   ch_ren2;
   logic [127:0]  ch_rdata, ch_rdata2;
   logic [31:0]   lb_data_in, lb_data_in2;
   logic          lb_rd_valid, lb_rd_valid2;
   logic [15:0]   fault_count, fault_count2;
   logic [23:0]   fault_addr, fault_addr2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lb_region_mux dut (
      .clk(clk), .rst_n(rst_n), .lb_addr(lb_addr), .lb_strobe(lb_strobe), .lb_rd(lb_rd),
      .ch_write(ch_write), .ch_ren(ch_ren), .ch_rdata(ch_rdata), .lb_data_in(lb_data_in),
      .lb_rd_valid(lb_rd_valid), .fault_count(fault_count), .fault_addr(fault_addr)
   );

   lb_region_mux #(.BASES({4'd3, 4'd5, 4'd5, 4'd0})) dut_dup (
      .clk(clk), .rst_n(rst_n), .lb_addr(lb_addr2), .lb_strobe(lb_strobe2), .lb_rd(lb_rd2),
      .ch_write(ch_write2), .ch_ren(ch_ren2), .ch_rdata(ch_rdata2), .lb_data_in(lb_data_in2),
      .lb_rd_valid(lb_rd_valid2), .fault_count(fault_count2), .fault_addr(fault_addr2)
   );

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      lb_addr = 24'h100000;
      #1;
      n_vec++; if (ch_ren !== 4'b0000) begin n_err++; $display("FAIL reset_ch_ren: got %b want 0000", ch_ren); end
      n_vec++; if (lb_rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", lb_rd_valid); end
      n_vec++; if (lb_data_in !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", lb_data_in); end
      n_vec++; if (fault_count !== 16'h0) begin n_err++; $display("FAIL reset_fcount: got %h want 0", fault_count); end
      n_vec++; if (fault_addr !== 24'h0) begin n_err++; $display("FAIL reset_faddr: got %h want 0", fault_addr); end
      n_vec++; if (ch_write !== 4'b0000) begin n_err++; $display("FAIL reset_ch_write: got %b want 0000", ch_write); end
      rst_n = 1'b1;
   endtask

   task automatic test_write();
      @(negedge clk);
      lb_addr = 24'h200010; lb_rd = 1'b0; lb_strobe = 1'b1;
      #1;
      n_vec++; if (ch_write !== 4'b0100) begin n_err++; $display("FAIL write_strobe: got %b want 0100", ch_write); end
      @(negedge clk);
      lb_strobe = 1'b0;
      #1;
      n_vec++; if (ch_write !== 4'b0000) begin n_err++; $display("FAIL write_idle: got %b want 0000", ch_write); end
      n_vec++; if (ch_ren !== 4'b0000) begin n_err++; $display("FAIL write_no_ren: got %b want 0000", ch_ren); end
      n_vec++; if (fault_count !== 16'h0) begin n_err++; $display("FAIL write_fcount: got %h want 0", fault_count); end
   endtask

   task automatic test_read();
      @(negedge clk);
      lb_addr = 24'h100004; lb_rd = 1'b1; lb_strobe = 1'b1;
      #1;
      n_vec++; if (ch_write !== 4'b0000) begin n_err++; $display("FAIL read_no_write: got %b want 0000", ch_write); end
      @(negedge clk);
      lb_strobe = 1'b0;
      n_vec++; if (ch_ren !== 4'b0010) begin n_err++; $display("FAIL read_ren: got %b want 0010", ch_ren); end
      n_vec++; if (lb_rd_valid !== 1'b0) begin n_err++; $display("FAIL read_early1: got %b want 0", lb_rd_valid); end
      @(negedge clk);
      n_vec++; if (ch_ren !== 4'b0000) begin n_err++; $display("FAIL read_ren_pulse: got %b want 0000", ch_ren); end
      n_vec++; if (lb_rd_valid !== 1'b0) begin n_err++; $display("FAIL read_early2: got %b want 0", lb_rd_valid); end
      @(negedge clk);
      n_vec++; if (lb_rd_valid !== 1'b1) begin n_err++; $display("FAIL read_valid: got %b want 1", lb_rd_valid); end
      n_vec++; if (lb_data_in !== 32'h12345678) begin n_err++; $display("FAIL read_data: got %h want 12345678", lb_data_in); end
      @(negedge clk);
      n_vec++; if (lb_rd_valid !== 1'b0) begin n_err++; $display("FAIL read_valid_drop: got %b want 0", lb_rd_valid); end
      n_vec++; if (lb_data_in !== 32'h12345678) begin n_err++; $display("FAIL read_data_hold: got %h want 12345678", lb_data_in); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] addrs [3];
      logic [31:0] exp_d [3];
      addrs[0] = 24'h000000; addrs[1] = 24'h300000; addrs[2] = 24'h100000;
      exp_d[0] = 32'h11110000; exp_d[1] = 32'h33330000; exp_d[2] = 32'h12345678;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (k >= 3 && k <= 5) begin
            n_vec++; if (lb_rd_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid%0d: got %b want 1", k, lb_rd_valid); end
            n_vec++; if (lb_data_in !== exp_d[k-3]) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", k, lb_data_in, exp_d[k-3]); end
         end else if (k == 6) begin
            n_vec++; if (lb_rd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_tail: got %b want 0", lb_rd_valid); end
         end
         if (k < 3) begin
            lb_addr = addrs[k]; lb_rd = 1'b1; lb_strobe = 1'b1;
         end else begin
            lb_strobe = 1'b0;
         end
      end
   endtask

   task automatic test_unmapped();
      @(negedge clk);
      lb_addr = 24'h700000; lb_rd = 1'b1; lb_strobe = 1'b1;
      @(negedge clk);
      lb_strobe = 1'b0;
      n_vec++; if (ch_ren !== 4'b0000) begin n_err++; $display("FAIL unm_ren: got %b want 0000", ch_ren); end
      n_vec++; if (fault_count !== 16'h1) begin n_err++; $display("FAIL unm_fcount: got %h want 0001", fault_count); end
      n_vec++; if (fault_addr !== 24'h700000) begin n_err++; $display("FAIL unm_faddr: got %h want 700000", fault_addr); end
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (lb_rd_valid !== 1'b1) begin n_err++; $display("FAIL unm_valid: got %b want 1", lb_rd_valid); end
      n_vec++; if (lb_data_in !== 32'hdeadf00d) begin n_err++; $display("FAIL unm_data: got %h want deadf00d", lb_data_in); end
      lb_addr = 24'hf00000; lb_rd = 1'b0; lb_strobe = 1'b1;
      #1;
      n_vec++; if (ch_write !== 4'b0000) begin n_err++; $display("FAIL unm_no_write: got %b want 0000", ch_write); end
      repeat (65533) @(negedge clk);
      n_vec++; if (fault_count !== 16'hfffe) begin n_err++; $display("FAIL sat_pre: got %h want fffe", fault_count); end
      @(negedge clk);
      n_vec++; if (fault_count !== 16'hffff) begin n_err++; $display("FAIL sat_hit: got %h want ffff", fault_count); end
      repeat (4466) @(negedge clk);
      lb_strobe = 1'b0;
      n_vec++; if (fault_count !== 16'hffff) begin n_err++; $display("FAIL sat_hold: got %h want ffff", fault_count); end
      n_vec++; if (fault_addr !== 24'hf00000) begin n_err++; $display("FAIL sat_faddr: got %h want f00000", fault_addr); end
   endtask

   task automatic test_dup_bases();
      @(negedge clk);
      lb_addr2 = 24'h500000; lb_rd2 = 1'b1; lb_strobe2 = 1'b1;
      @(negedge clk);
      lb_strobe2 = 1'b0;
      n_vec++; if (ch_ren2 !== 4'b0010) begin n_err++; $display("FAIL dup_ren: got %b want 0010", ch_ren2); end
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (lb_rd_valid2 !== 1'b1) begin n_err++; $display("FAIL dup_valid: got %b want 1", lb_rd_valid2); end
      n_vec++; if (lb_data_in2 !== 32'h55551111) begin n_err++; $display("FAIL dup_data: got %h want 55551111", lb_data_in2); end
      n_vec++; if (fault_count2 !== 16'h0) begin n_err++; $display("FAIL dup_fcount: got %h want 0", fault_count2); end
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      lb_addr = 24'h100004; lb_rd = 1'b1; lb_strobe = 1'b1;
      @(negedge clk);
      lb_strobe = 1'b0;
      rst_n = 1'b0;
      #1;
      n_vec++; if (ch_ren !== 4'b0000) begin n_err++; $display("FAIL rst_mid_ren: got %b want 0000", ch_ren); end
      n_vec++; if (lb_data_in !== 32'h0) begin n_err++; $display("FAIL rst_mid_data: got %h want 0", lb_data_in); end
      n_vec++; if (fault_count !== 16'h0) begin n_err++; $display("FAIL rst_mid_fcount: got %h want 0", fault_count); end
      n_vec++; if (fault_addr !== 24'h0) begin n_err++; $display("FAIL rst_mid_faddr: got %h want 0", fault_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 3; k <= 5; k++) begin
         @(negedge clk);
         n_vec++; if (lb_rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_novalid%0d: got %b want 0", k, lb_rd_valid); end
      end
      n_vec++; if (lb_data_in !== 32'h0) begin n_err++; $display("FAIL rst_mid_data_after: got %h want 0", lb_data_in); end
      @(negedge clk);
      lb_addr = 24'h300008; lb_rd = 1'b1; lb_strobe = 1'b1;
      @(negedge clk);
      lb_strobe = 1'b0;
      n_vec++; if (ch_ren !== 4'b1000) begin n_err++; $display("FAIL rst_next_ren: got %b want 1000", ch_ren); end
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (lb_rd_valid !== 1'b1) begin n_err++; $display("FAIL rst_next_valid: got %b want 1", lb_rd_valid); end
      n_vec++; if (lb_data_in !== 32'h33330000) begin n_err++; $display("FAIL rst_next_data: got %h want 33330000", lb_data_in); end
   endtask

   initial begin
      rst_n      = 1'b0;
      lb_addr    = '0; lb_strobe  = 1'b0; lb_rd  = 1'b0;
      lb_addr2   = '0; lb_strobe2 = 1'b0; lb_rd2 = 1'b0;
      ch_rdata   = {32'h33330000, 32'h22220000, 32'h12345678, 32'h11110000};
      ch_rdata2  = {32'h55553333, 32'h55552222, 32'h55551111, 32'h55550000};
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_unmapped();
      test_dup_bases();
      test_reset_mid_read();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
